// File: rtl/reg_writeback_queue.sv
// Write-side master for the main register file: queues {addr, data} results, drains one per
// cycle onto the registered write port, and forwards the youngest pending value to readers.
module reg_writeback_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       inValid,
    output logic                       inReady,
    input  logic [ADDR_W-1:0]          inAddr,
    input  logic [DATA_W-1:0]          inData,
    input  logic                       wbStall,
    output logic                       wbWrite,
    output logic [ADDR_W-1:0]          wbAddr,
    output logic [DATA_W-1:0]          wbData,
    input  logic [ADDR_W-1:0]          lookupAddr,
    output logic                       lookupHit,
    output logic [DATA_W-1:0]          lookupData,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] addrMem [DEPTH];
    logic [DATA_W-1:0] dataMem [DEPTH];

    logic [PtrW-1:0]   headQ;
    logic [PtrW-1:0]   tailQ;
    logic [CntW-1:0]   countQ;
    logic              wbWriteQ;
    logic [ADDR_W-1:0] wbAddrQ;
    logic [DATA_W-1:0] wbDataQ;

    logic push;
    logic pop;

    assign empty   = (countQ == '0);
    assign full    = (countQ == CntW'(DEPTH));
    assign inReady = !full && reset;
    assign push    = inValid && inReady;
    assign pop     = !empty && !wbStall;

    assign count   = countQ;
    assign wbWrite = wbWriteQ;
    assign wbAddr  = wbAddrQ;
    assign wbData  = wbDataQ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            headQ    <= '0;
            tailQ    <= '0;
            countQ   <= '0;
            wbWriteQ <= 1'b0;
            wbAddrQ  <= '0;
            wbDataQ  <= '0;
        end else begin
            if (push) begin
                tailQ <= tailQ + PtrW'(1);
            end
            if (pop) begin
                headQ   <= headQ + PtrW'(1);
                wbAddrQ <= addrMem[headQ];
                wbDataQ <= dataMem[headQ];
            end
            wbWriteQ <= pop;
            case ({push, pop})
                2'b10:   countQ <= countQ + CntW'(1);
                2'b01:   countQ <= countQ - CntW'(1);
                default: countQ <= countQ;
            endcase
        end
    end

    // Storage needs no reset: validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            addrMem[tailQ] <= inAddr;
            dataMem[tailQ] <= inData;
        end
    end

    // Walk oldest to youngest so later matches override earlier ones; the output stage is
    // older than every queued entry, so it is considered first.
    logic [PtrW-1:0] idx;

    always_comb begin
        idx        = '0;
        lookupHit  = wbWriteQ && (wbAddrQ == lookupAddr);
        lookupData = lookupHit ? wbDataQ : '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = headQ + PtrW'(i);
            if ((CntW'(i) < countQ) && (addrMem[idx] == lookupAddr)) begin
                lookupHit  = 1'b1;
                lookupData = dataMem[idx];
            end
        end
    end

endmodule
